// File: rtl/soc_it_burst_handler.sv
// SoC-IT slave burst handler: one descriptor per burst to the AXI side, then paces data beats.
// Latency: start sampled at edge N -> descriptor req high after edge N+1 (address already valid).
// Backpressure: req held until ack (or timeout); beats move only on slave/AXI handshakes; one-entry slot.
module soc_it_burst_handler #(
  parameter int C_SLV_INTERFACE_WIDTH = 128,
  parameter int C_SLV_ADDRESS_WIDTH   = 64,
  parameter int C_SLV_BURST_LENGTH    = 13,
  parameter int C_TIMEOUT             = 1024,
  parameter int XFER_PARAMS_WIDTH     = C_SLV_ADDRESS_WIDTH + C_SLV_BURST_LENGTH + 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           slave_burst_start,
  input  logic [C_SLV_BURST_LENGTH-1:0]  slave_burst_length,
  input  logic                           slave_burst_rnw,
  input  logic [C_SLV_ADDRESS_WIDTH-1:0] slave_address,
  input  logic                           slave_address_valid,
  output logic                           slave_address_ack,
  input  logic                           slave_wrreq,
  output logic                           slave_wrack,
  input  logic                           slave_rdreq,
  output logic                           slave_rdack,
  output logic [XFER_PARAMS_WIDTH-1:0]   xfer_params_o,
  output logic                           xfer_params_req_o,
  input  logic                           xfer_params_ack_i,
  output logic                           soc_it_wvalid_o,
  input  logic                           soc_it_wready_i,
  output logic                           soc_it_wlast_o,
  output logic                           soc_it_rready_o,
  input  logic                           soc_it_rvalid_i,
  input  logic                           soc_it_rlast_i,
  output logic                           busy_o,
  output logic [3:0]                     err_o,
  input  logic                           err_clr_i
);

  localparam int BL       = C_SLV_BURST_LENGTH;
  localparam int BLP1     = BL + 1;
  localparam int BYTES    = C_SLV_INTERFACE_WIDTH / 8;
  localparam int BSH      = $clog2(BYTES);
  localparam int TW       = (C_TIMEOUT > 2) ? $clog2(C_TIMEOUT) : 1;
  localparam int TMO_LAST_I = (C_TIMEOUT > 0) ? C_TIMEOUT - 1 : 0;
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_LAST_I);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SEND_DESCR = 3'd1,
    WRITE      = 3'd2,
    READ       = 3'd3,
    DRAIN      = 3'd4
  } state_t;

  state_t state_q, state_d;

  // pending burst slot
  logic                           slot_full_q;
  logic [C_SLV_ADDRESS_WIDTH-1:0] slot_addr_q;
  logic [BL-1:0]                  slot_len_q;
  logic [BL-1:0]                  slot_beats_q;
  logic                           slot_rnw_q;

  // active burst
  logic          cur_rnw_q;
  logic [BL-1:0] cur_last_q;
  logic [BL-1:0] beat_cnt_q;
  logic [TW-1:0] tmo_cnt_q;

  // FSM event strobes
  logic load_descr, descr_ack, tmo_hit, beat_inc, rd_mismatch;
  logic last_beat;

  logic          start_nz;
  logic [BLP1-1:0] len_round;
  logic [BL-1:0] beats_calc;

  // beats = ceil(len / BYTES); one extra bit keeps the rounding add from overflowing
  assign len_round  = {1'b0, slave_burst_length} + BLP1'(BYTES - 1);
  assign beats_calc = BL'(len_round >> BSH);
  assign start_nz   = slave_burst_start && (slave_burst_length != '0);
  assign last_beat  = (beat_cnt_q == cur_last_q);
  assign busy_o     = (state_q != IDLE) || slot_full_q;

  // state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // next state, beat-level handshakes and event strobes
  always_comb begin
    state_d           = state_q;
    load_descr        = 1'b0;
    descr_ack         = 1'b0;
    tmo_hit           = 1'b0;
    beat_inc          = 1'b0;
    rd_mismatch       = 1'b0;
    slave_address_ack = 1'b0;
    slave_wrack       = 1'b0;
    slave_rdack       = 1'b0;
    soc_it_wvalid_o   = 1'b0;
    soc_it_wlast_o    = 1'b0;
    soc_it_rready_o   = 1'b0;
    case (state_q)
      IDLE: begin
        if (slot_full_q && slave_address_valid) begin
          load_descr = 1'b1;
          state_d    = SEND_DESCR;
        end
      end
      SEND_DESCR: begin
        if (xfer_params_ack_i) begin
          descr_ack = 1'b1;
          state_d   = cur_rnw_q ? READ : WRITE;
        end else if ((C_TIMEOUT != 0) && (tmo_cnt_q == TMO_LAST)) begin
          tmo_hit = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        slave_address_ack = 1'b1;
        soc_it_wvalid_o   = slave_wrreq;
        slave_wrack       = slave_wrreq & soc_it_wready_i;
        soc_it_wlast_o    = last_beat;
        if (slave_wrreq && soc_it_wready_i) begin
          if (last_beat) state_d  = IDLE;
          else           beat_inc = 1'b1;
        end
      end
      READ: begin
        slave_address_ack = 1'b1;
        soc_it_rready_o   = slave_rdreq;
        slave_rdack       = slave_rdreq & soc_it_rvalid_i;
        if (slave_rdreq && soc_it_rvalid_i) begin
          if (soc_it_rlast_i) begin
            // rlast ahead of the expected final beat is a short read
            rd_mismatch = !last_beat;
            state_d     = IDLE;
          end else if (last_beat) begin
            // AXI side has more beats than the slave asked for; swallow them
            rd_mismatch = 1'b1;
            state_d     = DRAIN;
          end else begin
            beat_inc = 1'b1;
          end
        end
      end
      DRAIN: begin
        slave_address_ack = 1'b1;
        soc_it_rready_o   = 1'b1;
        if (soc_it_rvalid_i && soc_it_rlast_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // slot capture; the slot frees as its burst moves to SEND_DESCR, same-cycle start refills it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      slot_full_q  <= 1'b0;
      slot_addr_q  <= '0;
      slot_len_q   <= '0;
      slot_beats_q <= '0;
      slot_rnw_q   <= 1'b0;
    end else if (start_nz && (!slot_full_q || load_descr)) begin
      slot_full_q  <= 1'b1;
      slot_addr_q  <= slave_address;
      slot_len_q   <= slave_burst_length;
      slot_beats_q <= beats_calc;
      slot_rnw_q   <= slave_burst_rnw;
    end else if (load_descr) begin
      slot_full_q  <= 1'b0;
    end
  end

  // descriptor request, its hold/timeout, and per-burst context
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xfer_params_o     <= '0;
      xfer_params_req_o <= 1'b0;
      cur_rnw_q         <= 1'b0;
      cur_last_q        <= '0;
      tmo_cnt_q         <= '0;
    end else if (load_descr) begin
      xfer_params_o     <= {1'b1, slot_rnw_q, slot_len_q, slot_addr_q};
      xfer_params_req_o <= 1'b1;
      cur_rnw_q         <= slot_rnw_q;
      cur_last_q        <= slot_beats_q - BL'(1);
      tmo_cnt_q         <= '0;
    end else if (descr_ack) begin
      xfer_params_req_o <= 1'b0;
    end else if (tmo_hit) begin
      xfer_params_req_o <= 1'b0;
      xfer_params_o     <= '0;
    end else if (state_q == SEND_DESCR) begin
      tmo_cnt_q         <= tmo_cnt_q + TW'(1);
    end
  end

  // data beat counter, restarted for every accepted descriptor
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)        beat_cnt_q <= '0;
    else if (descr_ack) beat_cnt_q <= '0;
    else if (beat_inc)  beat_cnt_q <= beat_cnt_q + BL'(1);
  end

  // sticky error flags; a fresh error outranks a same-cycle clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_o <= '0;
    end else begin
      err_o <= (err_o & ~{4{err_clr_i}}) |
               {start_nz && slot_full_q && !load_descr,
                rd_mismatch,
                slave_burst_start && (slave_burst_length == '0),
                tmo_hit};
    end
  end

endmodule

// File: tb/tb_soc_it_burst_handler.sv
module tb_soc_it_burst_handler;

  localparam int W     = 128;
  localparam int AW    = 64;
  localparam int BL    = 13;
  localparam int TMO   = 8;
  localparam int XPW   = AW + BL + 2;
  localparam int BYTES = W / 8;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           slave_burst_start = 1'b0;
  logic [BL-1:0]  slave_burst_length = '0;
  logic           slave_burst_rnw = 1'b0;
  logic [AW-1:0]  slave_address = '0;
  logic           slave_address_valid = 1'b1;
  logic           slave_address_ack;
  logic           slave_wrreq = 1'b0;
  logic           slave_wrack;
  logic           slave_rdreq = 1'b0;
  logic           slave_rdack;
  logic [XPW-1:0] xfer_params_o;
  logic           xfer_params_req_o;
  logic           xfer_params_ack_i = 1'b0;
  logic           soc_it_wvalid_o;
  logic           soc_it_wready_i = 1'b0;
  logic           soc_it_wlast_o;
  logic           soc_it_rready_o;
  logic           soc_it_rvalid_i = 1'b0;
  logic           soc_it_rlast_i = 1'b0;
  logic           busy_o;
  logic [3:0]     err_o;
  logic           err_clr_i = 1'b0;

  int         n_run  = 0;
  int         n_fail = 0;
  logic [3:0] exp_err = '0;

  always #5 clk_i = ~clk_i;

  soc_it_burst_handler #(
    .C_SLV_INTERFACE_WIDTH(W),
    .C_SLV_ADDRESS_WIDTH(AW),
    .C_SLV_BURST_LENGTH(BL),
    .C_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .slave_burst_start(slave_burst_start), .slave_burst_length(slave_burst_length),
    .slave_burst_rnw(slave_burst_rnw), .slave_address(slave_address),
    .slave_address_valid(slave_address_valid), .slave_address_ack(slave_address_ack),
    .slave_wrreq(slave_wrreq), .slave_wrack(slave_wrack),
    .slave_rdreq(slave_rdreq), .slave_rdack(slave_rdack),
    .xfer_params_o(xfer_params_o), .xfer_params_req_o(xfer_params_req_o),
    .xfer_params_ack_i(xfer_params_ack_i),
    .soc_it_wvalid_o(soc_it_wvalid_o), .soc_it_wready_i(soc_it_wready_i),
    .soc_it_wlast_o(soc_it_wlast_o),
    .soc_it_rready_o(soc_it_rready_o), .soc_it_rvalid_i(soc_it_rvalid_i),
    .soc_it_rlast_i(soc_it_rlast_i),
    .busy_o(busy_o), .err_o(err_o), .err_clr_i(err_clr_i)
  );

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference: beat count and descriptor layout straight from the burst parameters
  function automatic int model_beats(input int len);
    return (len + BYTES - 1) / BYTES;
  endfunction

  function automatic logic [XPW-1:0] model_descr(input int len, input bit rnw, input logic [AW-1:0] addr);
    logic [BL-1:0] l;
    l = len[BL-1:0];
    return {1'b1, rnw, l, addr};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val(tag, {xfer_params_o, xfer_params_req_o, busy_o, err_o, slave_address_ack,
                    slave_wrack, slave_rdack, soc_it_wvalid_o, soc_it_wlast_o, soc_it_rready_o}, '0);
  endtask

  task automatic clear_errors();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    exp_err   = '0;
    check_val("err_cleared", err_o, 4'b0000);
  endtask

  task automatic pulse_start(input int len, input bit rnw, input logic [AW-1:0] addr);
    slave_burst_start  = 1'b1;
    slave_burst_length = len[BL-1:0];
    slave_burst_rnw    = rnw;
    slave_address      = addr;
    tick();
    slave_burst_start  = 1'b0;
  endtask

  // entered just after the capture edge; ends just after the ack edge
  task automatic descr_phase(input int len, input bit rnw, input logic [AW-1:0] addr, input int ack_dly);
    check_val("req_latency", xfer_params_req_o, 1'b0);
    check_val("busy_slot", busy_o, 1'b1);
    tick();
    check_val("req_rise", xfer_params_req_o, 1'b1);
    check_val("descr", xfer_params_o, model_descr(len, rnw, addr));
    for (int k = 0; k < ack_dly; k++) begin
      tick();
      check_val("req_hold", {xfer_params_req_o, xfer_params_o}, {1'b1, model_descr(len, rnw, addr)});
    end
    xfer_params_ack_i = 1'b1;
    tick();
    xfer_params_ack_i = 1'b0;
    check_val("req_drop", xfer_params_req_o, 1'b0);
    check_val("addr_ack", slave_address_ack, 1'b1);
  endtask

  task automatic write_data(input int beats);
    int i;
    int cyc;
    bit hs;
    i = 0;
    cyc = 0;
    while (i < beats && cyc < 20000) begin
      slave_wrreq     = ($urandom_range(0, 3) != 0);
      soc_it_wready_i = ($urandom_range(0, 3) != 0);
      #1;
      hs = slave_wrreq & soc_it_wready_i;
      check_val("wvalid", soc_it_wvalid_o, slave_wrreq);
      check_val("wrack", slave_wrack, hs);
      check_val("wlast", soc_it_wlast_o, (i == beats - 1));
      tick();
      if (hs) i++;
      cyc++;
    end
    slave_wrreq     = 1'b0;
    soc_it_wready_i = 1'b0;
    check_val("wr_idle", slave_address_ack, 1'b0);
  endtask

  // rlast_at: beat index the AXI side flags last; beyond beats-1 means an overrun
  task automatic read_data(input int beats, input int rlast_at);
    int i;
    int cyc;
    bit drain;
    bit done;
    i = 0;
    cyc = 0;
    drain = 0;
    done = 0;
    while (!done && cyc < 20000) begin
      slave_rdreq     = ($urandom_range(0, 3) != 0);
      soc_it_rvalid_i = ($urandom_range(0, 3) != 0);
      soc_it_rlast_i  = soc_it_rvalid_i && (i == rlast_at);
      #1;
      check_val("rd_addr_ack", slave_address_ack, 1'b1);
      if (!drain) begin
        check_val("rready", soc_it_rready_o, slave_rdreq);
        check_val("rdack", slave_rdack, slave_rdreq & soc_it_rvalid_i);
        if (slave_rdreq && soc_it_rvalid_i) begin
          if (soc_it_rlast_i) begin
            done = 1;
            if (i != beats - 1) exp_err[2] = 1'b1;
          end else if (i == beats - 1) begin
            drain = 1;
            exp_err[2] = 1'b1;
          end
          i++;
        end
      end else begin
        check_val("drain_rready", soc_it_rready_o, 1'b1);
        check_val("drain_rdack", slave_rdack, 1'b0);
        if (soc_it_rvalid_i) begin
          if (soc_it_rlast_i) done = 1;
          i++;
        end
      end
      tick();
      cyc++;
    end
    slave_rdreq     = 1'b0;
    soc_it_rvalid_i = 1'b0;
    soc_it_rlast_i  = 1'b0;
    check_val("rd_idle", slave_address_ack, 1'b0);
  endtask

  task automatic run_burst(input int len, input bit rnw, input int rlast_at);
    logic [AW-1:0] addr;
    addr = {$urandom, $urandom};
    pulse_start(len, rnw, addr);
    descr_phase(len, rnw, addr, $urandom_range(0, 5));
    if (rnw) read_data(model_beats(len), rlast_at);
    else     write_data(model_beats(len));
    check_val("burst_err", err_o, exp_err);
    check_val("burst_busy", busy_o, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int len;
    int beats;
    int rlast_at;
    int kind;
    bit rnw;
    logic [AW-1:0] addr_a;
    logic [AW-1:0] addr_b;

    #1;
    check_outputs_zero("reset_outputs");
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    check_outputs_zero("post_reset_idle");

    // write len=64 -> 4 beats, wlast on beat 3 only
    run_burst(64, 1'b0, 0);
    // read len=40 -> 3 beats: clean finish, then short read
    run_burst(40, 1'b1, 2);
    clear_errors();
    run_burst(40, 1'b1, 1);
    check_val("short_read_err", err_o, 4'b0100);
    clear_errors();
    // read len=32 with overrun of two beats
    run_burst(32, 1'b1, 3);
    check_val("overrun_err", err_o, 4'b0100);
    clear_errors();
    // largest length: 8191 bytes -> 512 beats
    run_burst(8191, 1'b0, 0);

    // descriptor timeout; ack seen while idle must have no effect
    pulse_start(16, 1'b0, 64'h1234);
    tick();
    cnt = 0;
    while (xfer_params_req_o && cnt < 50) begin
      cnt++;
      tick();
    end
    check_val("tmo_cycles", cnt, TMO);
    exp_err[0] = 1'b1;
    check_val("tmo_err", err_o, exp_err);
    check_val("tmo_idle", {busy_o, xfer_params_req_o, slave_address_ack}, 3'b000);
    xfer_params_ack_i = 1'b1;
    tick();
    xfer_params_ack_i = 1'b0;
    check_val("ack_ignored_idle", {busy_o, slave_address_ack}, 2'b00);
    clear_errors();

    // error set and clear in the same cycle: set wins
    err_clr_i = 1'b1;
    pulse_start(0, 1'b0, 64'h0);
    err_clr_i = 1'b0;
    check_val("set_beats_clr", err_o, 4'b0010);
    clear_errors();

    // address_valid low holds the burst in the slot
    slave_address_valid = 1'b0;
    addr_a = 64'hCAFE_0000_0000_0100;
    pulse_start(48, 1'b0, addr_a);
    for (int k = 0; k < 3; k++) begin
      check_val("addr_invalid_hold", {xfer_params_req_o, busy_o}, 2'b01);
      tick();
    end
    slave_address_valid = 1'b1;
    descr_phase(48, 1'b0, addr_a, 1);
    write_data(model_beats(48));

    // back-to-back: second start captured during the data phase, third overflows
    addr_a = 64'hA000;
    addr_b = 64'hB000;
    pulse_start(64, 1'b0, addr_a);
    descr_phase(64, 1'b0, addr_a, 0);
    for (int j = 0; j < 4; j++) begin
      slave_wrreq        = 1'b1;
      soc_it_wready_i    = 1'b1;
      slave_burst_start  = (j < 2);
      slave_burst_length = (j == 0) ? BL'(16) : BL'(32);
      slave_address      = (j == 0) ? addr_b : 64'hC000;
      #1;
      check_val("b2b_wlast", soc_it_wlast_o, (j == 3));
      tick();
    end
    slave_burst_start = 1'b0;
    slave_wrreq       = 1'b0;
    soc_it_wready_i   = 1'b0;
    exp_err[3] = 1'b1;
    check_val("overflow_err", err_o, exp_err);
    descr_phase(16, 1'b0, addr_b, 1);
    write_data(1);
    check_val("b2b_idle", busy_o, 1'b0);
    clear_errors();

    // randomized bursts
    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 5);
      len  = (kind == 0) ? 1 : (kind == 1) ? 16 : (kind == 2) ? 17 : $urandom_range(1, 200);
      rnw  = $urandom_range(0, 1);
      beats = model_beats(len);
      kind = $urandom_range(0, 2);
      if (kind == 1 && beats > 1) rlast_at = $urandom_range(0, beats - 2);
      else if (kind == 2)         rlast_at = beats - 1 + $urandom_range(1, 3);
      else                        rlast_at = beats - 1;
      run_burst(len, rnw, rlast_at);
      clear_errors();
    end

    // asynchronous reset in the middle of a read
    pulse_start(48, 1'b1, 64'hDEAD);
    descr_phase(48, 1'b1, 64'hDEAD, 0);
    slave_rdreq     = 1'b1;
    soc_it_rvalid_i = 1'b1;
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    slave_rdreq     = 1'b0;
    soc_it_rvalid_i = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    exp_err = '0;
    pulse_start(0, 1'b0, 64'h40);
    check_val("zero_len_err", err_o, 4'b0010);
    check_val("zero_len_busy", busy_o, 1'b0);
    tick();
    check_val("zero_len_noreq", xfer_params_req_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
